// File: rtl/memory_out_pkg.sv
// Shared widths, queue entry layout and drain FSM states for the bus write-out stage.
package memory_out_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/mem_out_fifo.sv
// Synchronous FIFO of address/data entries; a push into a full queue is taken
// only when the head is popped in the same cycle.
module mem_out_fifo
   import memory_out_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  entry_t           din_i,
   output entry_t           head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               empty_q;
   logic               push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop_i && !empty_q;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/memory_out_manager.sv
// Posted-write buffer between the core and the bus: queues address/data pairs
// and, once commanded, drains them over a valid/ready handshake.
//
// state | meaning
// IDLE  | collecting writes, bus outputs held at zero
// DRAIN | presenting head entry, popping on each PReady until queue empty
module memory_out_manager
   import memory_out_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Set,
   input  logic              Enqueue,
   input  logic              PReady,
   input  logic [ADDR_W-1:0] AdressIn,
   input  logic [DATA_W-1:0] DataIn,
   output logic              Empty,
   output logic              Busy,
   output logic              Trans,
   output logic [DATA_W-1:0] DataOut,
   output logic [ADDR_W-1:0] AdressOut
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t           state_q, state_d;
   entry_t           head;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             fifo_full_unused;
   logic             pop;

   assign pop = (state_q == DRAIN) && PReady;

   mem_out_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .push_i  (Enqueue),
      .pop_i   (pop),
      .din_i   ('{addr: AdressIn, data: DataIn}),
      .head_o  (head),
      .count_o (count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full_unused)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A push alongside the last pop keeps the drain going with the new entry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (Set && !fifo_empty) state_d = DRAIN;
         DRAIN:   if (pop && (count == CNT_W'(1)) && !Enqueue) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign Busy      = (state_q == DRAIN);
   assign Trans     = Busy;
   assign Empty     = fifo_empty;
   assign AdressOut = Busy ? head.addr : '0;
   assign DataOut   = Busy ? head.data : '0;

endmodule

// File: tb/tb_memory_out_manager.sv
// Bench for memory_out_manager: directed scenarios plus random traffic compared
// against a queue-based reference model.
module tb_memory_out_manager;

   localparam int DEPTH = 8;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0, Set = 1'b0, Enqueue = 1'b0, PReady = 1'b0;
   logic [15:0] AdressIn = '0, DataIn = '0;
   logic        Empty, Busy, Trans;
   logic [15:0] DataOut, AdressOut;

   int checks = 0;
   int errors = 0;

   logic [31:0] mq[$];
   bit          m_busy = 1'b0;

   memory_out_manager #(.DEPTH(DEPTH)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Set       (Set),
      .Enqueue   (Enqueue),
      .PReady    (PReady),
      .AdressIn  (AdressIn),
      .DataIn    (DataIn),
      .Empty     (Empty),
      .Busy      (Busy),
      .Trans     (Trans),
      .DataOut   (DataOut),
      .AdressOut (AdressOut)
   );

   always #5 Clk = ~Clk;

   // Drive one cycle of inputs, advance one edge and update the reference model.
   task automatic step(input logic r, input logic s, input logic e, input logic p,
                       input logic [15:0] a, input logic [15:0] d);
      int  n0;
      bit  pop, push;
      Rst = r; Set = s; Enqueue = e; PReady = p; AdressIn = a; DataIn = d;
      @(posedge Clk);
      if (r) begin
         mq.delete();
         m_busy = 1'b0;
      end else begin
         n0   = mq.size();
         pop  = m_busy && p;
         push = e && (n0 < DEPTH || pop);
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back({a, d});
         if (!m_busy && s && n0 > 0) m_busy = 1'b1;
         else if (m_busy && mq.size() == 0) m_busy = 1'b0;
      end
      #1;
      Rst = 1'b0; Set = 1'b0; Enqueue = 1'b0; PReady = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 16'h0, 16'h0);
      step(1, 1, 1, 1, 16'h1234, 16'h5678);
      checks++;
      if ({Empty, Busy, Trans} !== 3'b100 || DataOut !== 16'h0 || AdressOut !== 16'h0) begin
         errors++;
         $display("FAIL reset: E/B/T=%b%b%b addr=%h data=%h, required 100 0000 0000",
                  Empty, Busy, Trans, AdressOut, DataOut);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ea[3] = '{16'h0010, 16'h0011, 16'h0012};
      logic [15:0] ed[3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, ea[i], ed[i]);
      checks++;
      if (Empty !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_fill: Empty=%b Busy=%b, required 0 0", Empty, Busy);
      end
      step(0, 1, 0, 1, 16'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (Trans !== 1'b1 || Busy !== 1'b1 || AdressOut !== ea[i] || DataOut !== ed[i]) begin
            errors++;
            $display("FAIL basic_head%0d: T=%b B=%b %h/%h, required 1 1 %h/%h",
                     i, Trans, Busy, AdressOut, DataOut, ea[i], ed[i]);
         end
         step(0, 0, 0, 1, 16'h0, 16'h0);
      end
      checks++;
      if ({Empty, Busy, Trans} !== 3'b100 || AdressOut !== 16'h0 || DataOut !== 16'h0) begin
         errors++;
         $display("FAIL basic_done: E/B/T=%b%b%b %h/%h, required 100 0000/0000",
                  Empty, Busy, Trans, AdressOut, DataOut);
      end
   endtask

   task automatic test_backpressure();
      step(0, 0, 1, 0, 16'h0100, 16'h1111);
      step(0, 0, 1, 0, 16'h0101, 16'h2222);
      step(0, 1, 0, 0, 16'h0, 16'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (Trans !== 1'b1 || AdressOut !== 16'h0100 || DataOut !== 16'h1111) begin
            errors++;
            $display("FAIL bp_hold%0d: T=%b %h/%h, required 1 0100/1111",
                     i, Trans, AdressOut, DataOut);
         end
         step(0, 0, 0, 0, 16'h0, 16'h0);
      end
      step(0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Trans !== 1'b1 || AdressOut !== 16'h0101 || DataOut !== 16'h2222) begin
         errors++;
         $display("FAIL bp_second: T=%b %h/%h, required 1 0101/2222", Trans, AdressOut, DataOut);
      end
      step(0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Busy !== 1'b0 || Empty !== 1'b1) begin
         errors++;
         $display("FAIL bp_done: Busy=%b Empty=%b, required 0 1", Busy, Empty);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 16'h0200 + 16'(i), 16'h5A00 + 16'(i));
      step(0, 1, 0, 0, 16'h0, 16'h0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (Trans !== 1'b1 || AdressOut !== 16'h0200 + 16'(i) || DataOut !== 16'h5A00 + 16'(i)) begin
            errors++;
            $display("FAIL ovf_head%0d: T=%b %h/%h, required 1 %h/%h", i, Trans, AdressOut,
                     DataOut, 16'h0200 + 16'(i), 16'h5A00 + 16'(i));
         end
         step(0, 0, 0, 1, 16'h0, 16'h0);
      end
      checks++;
      if (Busy !== 1'b0 || Empty !== 1'b1 || Trans !== 1'b0) begin
         errors++;
         $display("FAIL ovf_ninth_lost: B=%b E=%b T=%b, required 0 1 0", Busy, Empty, Trans);
      end
   endtask

   task automatic test_set_empty();
      step(0, 1, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Busy !== 1'b0 || Trans !== 1'b0) begin
         errors++;
         $display("FAIL set_empty: Busy=%b Trans=%b, required 0 0", Busy, Trans);
      end
      step(0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Busy !== 1'b0 || Trans !== 1'b0 || AdressOut !== 16'h0) begin
         errors++;
         $display("FAIL set_empty_hold: B=%b T=%b addr=%h, required 0 0 0000", Busy, Trans, AdressOut);
      end
   endtask

   task automatic test_enq_during_drain();
      step(0, 0, 1, 0, 16'h0300, 16'h3333);
      step(0, 1, 0, 0, 16'h0, 16'h0);
      step(0, 0, 1, 1, 16'h0301, 16'h4444);
      checks++;
      if (Busy !== 1'b1 || AdressOut !== 16'h0301 || DataOut !== 16'h4444 || Empty !== 1'b0) begin
         errors++;
         $display("FAIL enq_drain_head: B=%b E=%b %h/%h, required 1 0 0301/4444",
                  Busy, Empty, AdressOut, DataOut);
      end
      step(0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Busy !== 1'b0 || Empty !== 1'b1) begin
         errors++;
         $display("FAIL enq_drain_done: Busy=%b Empty=%b, required 0 1", Busy, Empty);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'h0400 + 16'(i), 16'h7000 + 16'(i));
      step(0, 1, 0, 0, 16'h0, 16'h0);
      step(0, 0, 0, 1, 16'h0, 16'h0);
      step(1, 1, 1, 1, 16'hFFFF, 16'hFFFF);
      checks++;
      if ({Empty, Busy, Trans} !== 3'b100 || AdressOut !== 16'h0 || DataOut !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_drain: E/B/T=%b%b%b %h/%h, required 100 0000/0000",
                  Empty, Busy, Trans, AdressOut, DataOut);
      end
      step(0, 1, 0, 1, 16'h0, 16'h0);
      checks++;
      if (Busy !== 1'b0 || Empty !== 1'b1) begin
         errors++;
         $display("FAIL rst_queue_discarded: Busy=%b Empty=%b, required 0 1", Busy, Empty);
      end
   endtask

   task automatic test_random();
      logic [15:0] ea, ed;
      logic        eb, ee;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) != 0),
              16'($urandom), 16'($urandom));
         eb = m_busy;
         ee = (mq.size() == 0);
         ea = m_busy ? mq[0][31:16] : 16'h0;
         ed = m_busy ? mq[0][15:0]  : 16'h0;
         checks++;
         if (Busy !== eb || Trans !== eb || Empty !== ee || AdressOut !== ea || DataOut !== ed) begin
            errors++;
            $display("FAIL random_cyc%0d: B=%b T=%b E=%b %h/%h, required %b %b %b %h/%h",
                     i, Busy, Trans, Empty, AdressOut, DataOut, eb, eb, ee, ea, ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_set_empty();
      test_enq_during_drain();
      test_reset_mid_drain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
